// File: rtl/serial_add_pkg.sv
// Shared encodings for the bit-serial add/subtract controller.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, reused every cycle as the serial datapath slice.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic S
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one full_adder processes one bit pair per clock,
// LSB first, with the carry held in a flip-flop between cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic [1:0]   dbg_state
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  // Handshake: start is taken only in IDLE (ignored, not queued, otherwise);
  // done pulses for one cycle and sum/cout/ovf then hold until the next
  // accepted start.
  state_e             state_q;
  logic [W-1:0]       opa_q;
  logic [W-1:0]       opb_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [W-1:0]       sum_q;
  logic               busy_q;
  logic               done_q;
  logic               cout_q;
  logic               ovf_q;

  logic               fa_s;
  logic               fa_cout;

  full_adder u_fa (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Cin  (carry_q),
    .Cout (fa_cout),
    .S    (fa_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry.
            opa_q   <= a;
            opb_q   <= b ^ {W{op_sub == OP_SUB}};
            carry_q <= (op_sub != OP_ADD);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          sum_q   <= '0;
          state_q <= S_ADD;
        end
        S_ADD: begin
          carry_q <= fa_cout;
          sum_q   <= {fa_s, sum_q[W-1:1]};
          opa_q   <= {1'b0, opa_q[W-1:1]};
          opb_q   <= {1'b0, opb_q[W-1:1]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            // carry_q is the carry into the MSB here; flags are captured on
            // the final bit so they are valid together with done.
            cout_q  <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: arithmetic reference model plus
// cycle-accurate expectations for busy/done windows.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  serial_add_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [W+1:0] exp_q[$];      // {sum, cout, ovf}
  logic [W+1:0] last_res;
  logic [W+1:0] exp_e;
  logic         exp_busy;
  int checks   = 0;
  int errors   = 0;
  int neg_cnt  = 0;
  int free_neg = 0;
  int busy_lo  = 0;
  int busy_hi  = -1;
  int done_at  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [W+1:0] ref_model(input logic sub, input logic [W-1:0] av,
                                             input logic [W-1:0] bv);
    int ua, ub, sa, sb, ur, sr;
    logic [W-1:0] s;
    logic c, v;
    ua = int'(av);
    ub = int'(bv);
    sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
    sb = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
    if (sub) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur >= 2 ** W);
      sr = sa + sb;
    end
    s = ur[W-1:0];
    v = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
    return {s, c, v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sub, input logic [W-1:0] av, input logic [W-1:0] bv);
    int s;
    tick();
    start  = 1'b1;
    op_sub = sub;
    a      = av;
    b      = bv;
    s = neg_cnt + 1;   // negedge index of the cycle in which start is sampled
    if (s >= free_neg) begin
      exp_q.push_back(ref_model(sub, av, bv));
      busy_lo  = s + 1;
      busy_hi  = s + W + 1;
      done_at  = s + W + 2;
      free_neg = s + W + 3;
    end
    tick();
    start  = 1'b0;
    op_sub = 1'($urandom_range(0, 1));
    a      = W'($urandom_range(0, 2 ** W - 1));
    b      = W'($urandom_range(0, 2 ** W - 1));
  endtask

  task automatic wait_until(input int target);
    int n;
    n = 0;
    while (neg_cnt + 2 < target && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: got neg %0d expected reach %0d", neg_cnt, target);
    end
  endtask

  task automatic wait_free();
    wait_until(free_neg);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    exp_q.delete();
    busy_hi = -1;
    done_at = -1;
    tick();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    last_res = '0;
    rst_n    = 1'b1;
    free_neg = neg_cnt + 1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    neg_cnt++;
    if (rst_n) begin
      exp_busy = (neg_cnt >= busy_lo) && (neg_cnt <= busy_hi);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(neg_cnt == done_at));
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 expected no pending result");
        end else begin
          exp_e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(exp_e[W+1:2]));
          check("cout", 32'(cout), 32'(exp_e[1]));
          check("ovf", 32'(ovf), 32'(exp_e[0]));
          last_res = exp_e;
        end
      end else if (!exp_busy) begin
        check("hold", 32'({sum, cout, ovf}), 32'(last_res));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    op_sub   = 1'b0;
    a        = '0;
    b        = '0;
    last_res = '0;
    apply_reset();

    // directed vectors
    wait_free(); issue(OP_ADD, 4'd5, 4'd6);
    wait_free(); issue(OP_ADD, 4'd7, 4'd9);
    wait_free(); issue(OP_SUB, 4'd3, 4'd5);
    wait_free(); issue(OP_SUB, 4'd8, 4'd1);

    // second start two cycles after the first must be ignored
    wait_free(); issue(OP_ADD, 4'd2, 4'd3); issue(OP_SUB, 4'd15, 4'd1);

    // start during the DONE cycle is ignored as well
    wait_free(); issue(OP_ADD, 4'd4, 4'd4);
    wait_until(done_at); issue(OP_ADD, 4'd1, 4'd1);

    // reset while cnt == 2 aborts without a done pulse
    wait_free(); issue(OP_ADD, 4'd9, 4'd3);
    tick(); tick(); tick();
    apply_reset();
    wait_free(); issue(OP_SUB, 4'd6, 4'd2);

    // randomized operations with random gaps and stray starts
    for (int i = 0; i < 40; i++) begin
      wait_free();
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      issue(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(0, W + 2)); g++) tick();
        issue(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      end
    end

    wait_free();
    tick(); tick(); tick();
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
